// File: rtl/word_serializer.sv
// Framed serial transmitter: START_BIT, DATA_LENGTH data bits LSB-first, then a stop bit.
// Words arrive over valid/ready; a one-word hold register prefetches the next word during shifting.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | line idle, counters cleared, waiting for start
//   S_LOAD  | waiting for the first word of the frame
//   S_START | start bit on the line, hold may prefetch
//   S_SHIFT | data bits on the line, word boundaries refill shift_reg
//   S_STOP  | stop bit on the line, done pulses
module word_serializer #(
  parameter int   DATA_LENGTH = 16,
  parameter int   WORD_SIZE   = 8,
  parameter logic START_BIT   = 1'b0,
  parameter logic IDLE_BIT    = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 data_out,
  output logic                 busy,
  output logic                 RCO,
  output logic                 underrun,
  output logic                 done
);

  localparam int WORDS = DATA_LENGTH / WORD_SIZE;
  localparam int BIT_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam int WRD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int FCH_W = $clog2(WORDS + 1);
  localparam int FS_W  = FCH_W + 1;

  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_SIZE - 1);
  localparam logic [WRD_W-1:0] WORD_LAST = WRD_W'(WORDS - 1);
  localparam logic [FCH_W-1:0] FETCH_MAX = FCH_W'(WORDS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_SHIFT, S_STOP} state_t;

  state_t               state, state_nx;
  logic [WORD_SIZE-1:0] shift_reg;
  logic [WORD_SIZE-1:0] hold;
  logic                 hold_full;
  logic [BIT_W-1:0]     bit_cnt;
  logic [WRD_W-1:0]     word_cnt;
  logic [FCH_W-1:0]     fetch_cnt;

  logic             last_bit, last_word, hold_ready, hs, boundary;
  logic [FS_W-1:0]  fetch_sum;
  logic [FCH_W-1:0] fetch_nx;

  assign last_bit   = (bit_cnt == BIT_LAST);
  assign last_word  = (word_cnt == WORD_LAST);
  assign hold_ready = !hold_full && (fetch_cnt < FETCH_MAX);
  assign hs         = data_valid && data_ready;
  assign boundary   = (state == S_SHIFT) && last_bit && !last_word;
  assign busy       = (state != S_IDLE) || start;

  // An underrun fill consumes a word slot just like a real word; saturate at WORDS.
  assign fetch_sum = {1'b0, fetch_cnt} + FS_W'(hs) + FS_W'(underrun);
  assign fetch_nx  = (fetch_sum > FS_W'(WORDS)) ? FETCH_MAX : fetch_sum[FCH_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    data_ready = 1'b0;
    data_out   = IDLE_BIT;
    RCO        = 1'b0;
    underrun   = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_LOAD;
      S_LOAD: begin
        data_ready = 1'b1;
        if (data_valid) state_nx = S_START;
      end
      S_START: begin
        data_out   = START_BIT;
        data_ready = hold_ready;
        state_nx   = S_SHIFT;
      end
      S_SHIFT: begin
        data_out   = shift_reg[0];
        data_ready = hold_ready;
        RCO        = last_bit;
        underrun   = last_bit && !last_word && !hold_full;
        if (last_bit && last_word) state_nx = S_STOP;
      end
      S_STOP: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      fetch_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          hold_full <= 1'b0;
          bit_cnt   <= '0;
          word_cnt  <= '0;
          fetch_cnt <= '0;
        end
        S_LOAD: begin
          if (hs) begin
            shift_reg <= data_in;
            fetch_cnt <= FCH_W'(1);
          end
        end
        S_START, S_SHIFT: begin
          fetch_cnt <= fetch_nx;
          if (hs) begin
            hold      <= data_in;
            hold_full <= 1'b1;
          end else if (boundary && hold_full) begin
            hold_full <= 1'b0;
          end
          if (state == S_START) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
          end else if (!last_bit) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + BIT_W'(1);
          end else if (!last_word) begin
            bit_cnt   <= '0;
            word_cnt  <= word_cnt + WRD_W'(1);
            shift_reg <= hold_full ? hold : {WORD_SIZE{IDLE_BIT}};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
